// File: rtl/w_bus_arbiter.sv
// w_bus_arbiter: round-robin arbiter sharing one W bus master port between
// up to four per-thread requesters. A request is granted in IDLE, runs its bus
// cycle in BUS (ack or timeout) and reports back with a one-cycle rsp_ack in RESP.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req             per-requester request, held until its rsp_ack
//   req_write       per-requester direction (1 = write)
//   req_addr        packed per-requester address, requester i at [32i+31:32i]
//   req_data        packed per-requester write data, same packing
//   rsp_ack         one-cycle completion pulse to the granted requester
//   rsp_err         valid with rsp_ack, 1 = bus timeout
//   rsp_data        read data, valid with rsp_ack
//   W_ADDR          bus address
//   W_DATA_O        bus write data
//   W_WRITE         bus direction
//   W_STB           bus cycle active
//   W_ACK           bus acknowledge, sampled only while W_STB is high
//   W_DATA_I        bus read data, captured with W_ACK
module w_bus_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      req_write,
    input  logic [32*N_REQ-1:0]   req_addr,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      rsp_ack,
    output logic                  rsp_err,
    output logic [31:0]           rsp_data,
    output logic [31:0]           W_ADDR,
    output logic [31:0]           W_DATA_O,
    output logic                  W_WRITE,
    output logic                  W_STB,
    input  logic                  W_ACK,
    input  logic [31:0]           W_DATA_I
);

    localparam int unsigned DW = 32;
    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             err_q, err_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [DW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             write_q, write_d;
    logic             stb_q, stb_d;

    logic             pick_valid;
    logic [GW-1:0]    pick_idx;
    logic [GW-1:0]    scan_idx;
    logic [DW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             sel_write;
    logic [N_REQ-1:0] grant_onehot;

    // Round-robin pick: first active request scanning upward from last_q+1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = GW'((32'(last_q) + 32'd1 + k) % N_REQ);
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Select the picked requester's address, data and direction.
    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (GW'(i) == pick_idx) begin
                sel_addr  = req_addr[i*DW +: DW];
                sel_data  = req_data[i*DW +: DW];
                sel_write = req_write[i];
            end
        end
    end

    // One-hot of the latched grant, used for the completion pulse.
    always_comb begin
        grant_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_onehot[i] = (GW'(i) == grant_q);
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        stb_d   = stb_q;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_data;
                    write_d = sel_write;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (W_ACK) begin
                    rdata_d = write_q ? '0 : W_DATA_I;
                    stb_d   = 1'b0;
                    ack_d   = grant_onehot;
                    err_d   = 1'b0;
                    last_d  = grant_q;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // cnt_q counts completed BUS cycles, so W_STB has been high TIMEOUT cycles.
                    rdata_d = '0;
                    stb_d   = 1'b0;
                    ack_d   = grant_onehot;
                    err_d   = 1'b1;
                    last_d  = grant_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            stb_q   <= stb_d;
        end
    end

    assign rsp_ack  = ack_q;
    assign rsp_err  = err_q;
    assign rsp_data = rdata_q;
    assign W_ADDR   = addr_q;
    assign W_DATA_O = wdata_q;
    assign W_WRITE  = write_q;
    assign W_STB    = stb_q;

endmodule
